// File: rtl/cpu6_dmem_responder_pkg.sv
// Shared types and helpers for the CPU6 data-memory responder.
package cpu6_dmem_responder_pkg;

  localparam int CPU6_XLEN              = 32;
  localparam int CPU6_DMEM_WSTRB_WIDTH  = 4;

  typedef enum logic [1:0] {
    CPU6_DMEM_ST_IDLE = 2'd0,
    CPU6_DMEM_ST_WAIT = 2'd1,
    CPU6_DMEM_ST_RESP = 2'd2
  } dmem_state_e;

  // Misaligned or outside [base, win_end); win_end is one bit wider so the top of the map cannot wrap.
  function automatic logic dmem_addr_err(input logic [CPU6_XLEN-1:0] addr,
                                         input logic [CPU6_XLEN-1:0] base,
                                         input logic [CPU6_XLEN:0]   win_end);
    return (addr[1:0] != 2'b00) | (addr < base) | ({1'b0, addr} >= win_end);
  endfunction

endpackage

// File: rtl/cpu6_dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data memory (slave).
interface cpu6_dmem_responder_if
  import cpu6_dmem_responder_pkg::*;
#(
  parameter int XLEN = CPU6_XLEN
) ();

  logic                             req_valid;
  logic                             req_write;
  logic [XLEN-1:0]                  req_addr;
  logic [XLEN-1:0]                  req_wdata;
  logic [CPU6_DMEM_WSTRB_WIDTH-1:0] req_wstrb;
  logic                             req_ready;
  logic                             resp_valid;
  logic [XLEN-1:0]                  resp_rdata;
  logic                             resp_err;
  logic                             stall;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/cpu6_dmem_responder_ram.sv
// Backing word RAM: byte-enabled synchronous write, combinational read, no reset.
module cpu6_dmem_ram
  import cpu6_dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                             clk,
  input  logic                             we_i,
  input  logic [CPU6_DMEM_WSTRB_WIDTH-1:0] be_i,
  input  logic [AW-1:0]                    addr_i,
  input  logic [CPU6_XLEN-1:0]             wdata_i,
  output logic [CPU6_XLEN-1:0]             rdata_o
);

  logic [CPU6_XLEN-1:0] mem_q [DEPTH_WORDS];

  // Byte-lane write of the addressed word
  always_ff @(posedge clk) begin
    for (int b = 0; b < CPU6_DMEM_WSTRB_WIDTH; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cpu6_dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_STATES cycles, then returns a one-cycle response.
module cpu6_dmem_responder
  import cpu6_dmem_responder_pkg::*;
#(
  parameter int                     XLEN        = CPU6_XLEN,
  parameter int                     DEPTH_WORDS = 1024,
  parameter logic [CPU6_XLEN-1:0]   BASE_ADDR   = 32'h0000_2000,
  parameter int                     WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu6_dmem_responder_if.slave  bus
);

  localparam int                   AW      = $clog2(DEPTH_WORDS);
  localparam logic [CPU6_XLEN:0]   WIN_END = {1'b0, BASE_ADDR} + (CPU6_XLEN+1)'(4 * DEPTH_WORDS);

  dmem_state_e                      state_q, state_d;
  logic [3:0]                       cnt_q, cnt_d;
  logic                             write_q, write_d;
  logic [CPU6_XLEN-1:0]             addr_q, addr_d;
  logic [CPU6_XLEN-1:0]             wdata_q, wdata_d;
  logic [CPU6_DMEM_WSTRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                             err_q, err_d;
  logic                             resp_valid_q, resp_valid_d;
  logic [CPU6_XLEN-1:0]             resp_rdata_q, resp_rdata_d;
  logic                             resp_err_q, resp_err_d;
  logic                             enter_resp_s;
  logic                             ready_s;
  logic                             stall_s;
  logic                             ram_we_s;
  logic [CPU6_XLEN-1:0]             ram_rdata_s;

  // The _d copies of the request fields equal the live bus during acceptance, so a
  // zero-wait access can commit/read on the same edge that accepts it.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    err_d        = err_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    enter_resp_s = 1'b0;
    ready_s      = 1'b0;
    stall_s      = 1'b0;
    case (state_q)
      CPU6_DMEM_ST_IDLE: begin
        ready_s = 1'b1;
        if (bus.req_valid) begin
          stall_s = 1'b1;
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wstrb_d = bus.req_wstrb;
          err_d   = dmem_addr_err(bus.req_addr, BASE_ADDR, WIN_END);
          if (WAIT_STATES > 0) begin
            state_d = CPU6_DMEM_ST_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end else begin
            state_d      = CPU6_DMEM_ST_RESP;
            enter_resp_s = 1'b1;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      CPU6_DMEM_ST_WAIT: begin
        stall_s = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d      = CPU6_DMEM_ST_RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      CPU6_DMEM_ST_RESP: begin
        state_d = CPU6_DMEM_ST_IDLE;
      end
      default: begin
        state_d = CPU6_DMEM_ST_IDLE;
      end
    endcase
    if (enter_resp_s) begin
      resp_valid_d = 1'b1;
      resp_err_d   = err_d;
      resp_rdata_d = (write_d || err_d) ? '0 : ram_rdata_s;
    end else begin
      resp_valid_d = 1'b0;
    end
  end

  // A store held across a reset edge must never reach the RAM
  assign ram_we_s = enter_resp_s & write_d & ~err_d & reset;

  cpu6_dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we_s),
    .be_i    (wstrb_d),
    .addr_i  (addr_d[AW+1:2]),
    .wdata_i (wdata_d),
    .rdata_o (ram_rdata_s)
  );

  // State, request latch and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= CPU6_DMEM_ST_IDLE;
      cnt_q        <= 4'd0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      err_q        <= err_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus.req_ready  = ready_s;
  assign bus.stall      = stall_s;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule
